// File: rtl/ifetch_queue_pkg.sv
// mips_defs: constants and the fetch FSM encoding shared by the
// instruction-fetch front end of the 5-stage MIPS core.
//   INSN_W   : instruction word width
//   PC_STEP  : PC increment per sequential fetch
//   NOP_INSN : canonical no-op encoding
//   fetch_state_e : IDLE / RUN / FLUSH states of the fetch FSM
package mips_defs;

  localparam int INSN_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: ROM request/response and decode valid/ready bundle of the
// fetch front end.
//   rom_addr/rom_ce  : read request to the 1-cycle synchronous instruction ROM
//   rom_data         : ROM word, valid the cycle after rom_ce
//   out_valid/ready  : handshake to decode
//   out_pc/out_insn  : payload of the queue head
// master = fetch unit, slave = ROM plus decode side.
interface ifetch_queue_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_insn;

  modport master (
    output rom_addr,
    output rom_ce,
    input  rom_data,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_insn
  );

  modport slave (
    input  rom_addr,
    input  rom_ce,
    output rom_data,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_insn
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifetch_fifo: synchronous circular FIFO holding fetched {pc, insn} entries.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write din at the tail (ignored when full and not popping)
//   pop      : advance the head (ignored when empty)
//   clear    : empty the FIFO; wins over push and pop
//   dout     : head entry (registered storage, no bypass from din)
//   count    : occupied entries, 0..DEPTH
// Pointers are clog2(DEPTH) bits and wrap on their own since DEPTH is a
// power of two; count tells full from empty.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the current fill level.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (count_r != {CNT_W{1'b0}}) begin
      do_pop_s = pop;
    end else begin
      do_pop_s = 1'b0;
    end
    if (count_r < CNT_W'(DEPTH)) begin
      do_push_s = push;
    end else begin
      // A full queue may still take a push when the head leaves this cycle.
      do_push_s = push & do_pop_s;
    end
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end of the 5-stage MIPS core.
// Owns the PC, issues reads to a 1-cycle-latency synchronous ROM, buffers
// returned words in a DEPTH-entry queue and presents {pc, insn} to decode
// over valid/ready. A redirect flushes queued and in-flight fetches.
//   clk, rst     : clock, asynchronous active-low reset
//   fetch_en     : allow new ROM requests
//   redirect     : flush and restart at redirect_pc (bits [1:0] ignored)
//   bus (master) : rom_addr/rom_ce/rom_data and out_valid/out_ready/out_pc/out_insn
//   count        : occupied queue entries
module ifetch_queue
  import mips_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  ifetch_queue_if.master         bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PAY_W = ADDR_W + INSN_W;

  fetch_state_e      state_r;
  fetch_state_e      state_nx_s;
  logic [ADDR_W-1:0] pc_r;
  logic              epoch_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] req_pc_r;
  logic              req_epoch_r;

  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    occ_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              out_valid_s;
  logic [ADDR_W-1:0] target_pc_s;
  logic [PAY_W-1:0]  din_s;
  logic [PAY_W-1:0]  dout_s;

  // Word-align the redirect target by masking the byte offset.
  assign target_pc_s = redirect_pc & ~ADDR_W'(3);

  assign out_valid_s = (count_s != {CNT_W{1'b0}});

  // Handshake qualification. A redirect discards this cycle's pop and push:
  // the whole queue is cleared anyway, and a stale response must not land.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (redirect) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end else begin
      pop_s  = out_valid_s & bus.out_ready;
      push_s = inflight_r & (req_epoch_r == epoch_r);
    end
  end

  // Issue only while the queue can absorb the response after this edge:
  // occupancy after the edge plus the new request must fit in DEPTH.
  always_comb begin
    occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r}
            - {{CNT_W{1'b0}}, pop_s};
    issue_s = 1'b0;
    if ((state_r == ST_RUN) && fetch_en && !redirect
        && (occ_s < (CNT_W + 1)'(DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch FSM next-state logic; redirect forces FLUSH from any state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = redirect ? ST_FLUSH : ST_RUN;
      ST_RUN:   state_nx_s = redirect ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nx_s = redirect ? ST_FLUSH : ST_RUN;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // PC, epoch and in-flight request tracking. The epoch tags each request so
  // a response issued before a redirect is recognised as stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r        <= RESET_PC;
      epoch_r     <= 1'b0;
      inflight_r  <= 1'b0;
      req_pc_r    <= '0;
      req_epoch_r <= 1'b0;
    end else if (redirect) begin
      pc_r       <= target_pc_s;
      epoch_r    <= ~epoch_r;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r        <= pc_r + ADDR_W'(PC_STEP);
        req_pc_r    <= pc_r;
        req_epoch_r <= epoch_r;
      end
    end
  end

  assign din_s = {req_pc_r, bus.rom_data};

  ifetch_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (redirect),
    .din   (din_s),
    .dout  (dout_s),
    .count (count_s)
  );

  assign bus.rom_addr  = pc_r;
  assign bus.rom_ce    = issue_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = dout_s[PAY_W-1:INSN_W];
  assign bus.out_insn  = dout_s[INSN_W-1:0];
  assign count         = count_s;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue. A 32-bit/DEPTH=4 instance
// covers streaming, backpressure, redirects and async reset; an 8-bit
// instance starting at 0xF8 covers PC wrap. Both ROM models return the
// read address as the instruction word.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  logic        rst_w;
  logic        fetch_en_w;
  logic        redirect_w;
  logic [7:0]  redirect_pc_w;
  logic [2:0]  count_w;

  int errs;
  int checks;

  ifetch_queue_if #(.ADDR_W(32)) bus_m ();
  ifetch_queue_if #(.ADDR_W(8))  bus_w ();

  ifetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus_m),
    .count       (count)
  );

  ifetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) dut_w (
    .clk         (clk),
    .rst         (rst_w),
    .fetch_en    (fetch_en_w),
    .redirect    (redirect_w),
    .redirect_pc (redirect_pc_w),
    .bus         (bus_w),
    .count       (count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: one cycle latency, word = address.
  always @(posedge clk) begin
    if (bus_m.rom_ce) bus_m.rom_data <= bus_m.rom_addr;
    if (bus_w.rom_ce) bus_w.rom_data <= {24'h0, bus_w.rom_addr};
  end

  task automatic do_reset(input logic ready);
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    fetch_en = 1'b1;
    bus_m.out_ready = ready;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks += 6;
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b expected 0", bus_m.out_valid); end
    if (bus_m.rom_ce !== 1'b0) begin errs++; $display("FAIL reset_ce got %b expected 0", bus_m.rom_ce); end
    if (bus_m.rom_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got %h expected 0", bus_m.rom_addr); end
    if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d expected 0", count); end
    if (bus_m.out_pc !== 32'h0) begin errs++; $display("FAIL reset_pc got %h expected 0", bus_m.out_pc); end
    if (bus_m.out_insn !== 32'h0) begin errs++; $display("FAIL reset_insn got %h expected 0", bus_m.out_insn); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_a;
    logic [31:0] exp_o;
    do_reset(1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_a = 32'(4 * (i - 1));
      checks += 3;
      if (bus_m.rom_ce !== 1'b1) begin errs++; $display("FAIL stream_ce cyc %0d got %b expected 1", i, bus_m.rom_ce); end
      if (bus_m.rom_addr !== exp_a) begin errs++; $display("FAIL stream_addr cyc %0d got %h expected %h", i, bus_m.rom_addr, exp_a); end
      if (bus_m.out_valid !== (i >= 3)) begin errs++; $display("FAIL stream_valid cyc %0d got %b expected %b", i, bus_m.out_valid, (i >= 3)); end
      if (i >= 3) begin
        exp_o = 32'(4 * (i - 3));
        checks += 3;
        if (bus_m.out_pc !== exp_o) begin errs++; $display("FAIL stream_pc cyc %0d got %h expected %h", i, bus_m.out_pc, exp_o); end
        if (bus_m.out_insn !== exp_o) begin errs++; $display("FAIL stream_insn cyc %0d got %h expected %h", i, bus_m.out_insn, exp_o); end
        if (count !== 3'd1) begin errs++; $display("FAIL stream_count cyc %0d got %0d expected 1", i, count); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_o;
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks += 2;
        if (bus_m.out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid cyc %0d got %b expected 1", i, bus_m.out_valid); end
        if (bus_m.out_pc !== 32'h0) begin errs++; $display("FAIL bp_hold_pc cyc %0d got %h expected 0", i, bus_m.out_pc); end
      end
      if (i >= 5) begin
        checks++;
        if (bus_m.rom_ce !== 1'b0) begin errs++; $display("FAIL bp_ce cyc %0d got %b expected 0", i, bus_m.rom_ce); end
      end
    end
    checks++;
    if (count !== 3'd4) begin errs++; $display("FAIL bp_full got %0d expected 4", count); end
    bus_m.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_o = 32'(4 * k);
      checks += 2;
      if (bus_m.out_valid !== 1'b1) begin errs++; $display("FAIL bp_drain_valid pop %0d got %b expected 1", k, bus_m.out_valid); end
      if (bus_m.out_pc !== exp_o) begin errs++; $display("FAIL bp_drain_pc pop %0d got %h expected %h", k, bus_m.out_pc, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_o;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (count !== 3'd3) begin errs++; $display("FAIL redir_pre_count got %0d expected 3", count); end
    redirect = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    bus_m.out_ready = 1'b1;
    #1;
    checks += 3;
    if (count !== 3'd0) begin errs++; $display("FAIL redir_count got %0d expected 0", count); end
    if (bus_m.rom_ce !== 1'b0) begin errs++; $display("FAIL redir_flush_ce got %b expected 0", bus_m.rom_ce); end
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL redir_valid got %b expected 0", bus_m.out_valid); end
    @(negedge clk);
    checks += 2;
    if (bus_m.rom_ce !== 1'b1) begin errs++; $display("FAIL redir_issue_ce got %b expected 1", bus_m.rom_ce); end
    if (bus_m.rom_addr !== 32'h100) begin errs++; $display("FAIL redir_issue_addr got %h expected 100", bus_m.rom_addr); end
    @(negedge clk);
    checks++;
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL redir_stale got %b expected 0", bus_m.out_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_o = 32'h100 + 32'(4 * k);
      checks += 3;
      if (bus_m.out_valid !== 1'b1) begin errs++; $display("FAIL redir_out_valid %0d got %b expected 1", k, bus_m.out_valid); end
      if (bus_m.out_pc !== exp_o) begin errs++; $display("FAIL redir_out_pc %0d got %h expected %h", k, bus_m.out_pc, exp_o); end
      if (bus_m.out_insn !== exp_o) begin errs++; $display("FAIL redir_out_insn %0d got %h expected %h", k, bus_m.out_insn, exp_o); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    checks++;
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_flush1_valid got %b expected 0", bus_m.out_valid); end
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks += 2;
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_flush2_valid got %b expected 0", bus_m.out_valid); end
    if (bus_m.rom_ce !== 1'b0) begin errs++; $display("FAIL b2b_flush2_ce got %b expected 0", bus_m.rom_ce); end
    @(negedge clk);
    checks += 3;
    if (bus_m.rom_ce !== 1'b1) begin errs++; $display("FAIL b2b_issue_ce got %b expected 1", bus_m.rom_ce); end
    if (bus_m.rom_addr !== 32'h80) begin errs++; $display("FAIL b2b_issue_addr got %h expected 80", bus_m.rom_addr); end
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_early_valid got %b expected 0", bus_m.out_valid); end
    @(negedge clk);
    checks++;
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_stale_valid got %b expected 0", bus_m.out_valid); end
    @(negedge clk);
    checks += 2;
    if (bus_m.out_valid !== 1'b1) begin errs++; $display("FAIL b2b_first_valid got %b expected 1", bus_m.out_valid); end
    if (bus_m.out_pc !== 32'h80) begin errs++; $display("FAIL b2b_first_pc got %h expected 80", bus_m.out_pc); end
    @(negedge clk);
    checks++;
    if (bus_m.out_pc !== 32'h84) begin errs++; $display("FAIL b2b_second_pc got %h expected 84", bus_m.out_pc); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (count !== 3'd2) begin errs++; $display("FAIL arst_pre_count got %0d expected 2", count); end
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (bus_m.out_valid !== 1'b0) begin errs++; $display("FAIL arst_valid got %b expected 0", bus_m.out_valid); end
    if (bus_m.rom_ce !== 1'b0) begin errs++; $display("FAIL arst_ce got %b expected 0", bus_m.rom_ce); end
    if (count !== 3'd0) begin errs++; $display("FAIL arst_count got %0d expected 0", count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus_m.rom_ce !== 1'b1) begin errs++; $display("FAIL arst_restart_ce got %b expected 1", bus_m.rom_ce); end
    if (bus_m.rom_addr !== 32'h0) begin errs++; $display("FAIL arst_restart_addr got %h expected 0", bus_m.rom_addr); end
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (bus_m.out_valid !== 1'b1) begin errs++; $display("FAIL arst_first_valid got %b expected 1", bus_m.out_valid); end
    if (bus_m.out_pc !== 32'h0) begin errs++; $display("FAIL arst_first_pc got %h expected 0", bus_m.out_pc); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_o;
    rst_w = 1'b0;
    fetch_en_w = 1'b1;
    redirect_w = 1'b0;
    redirect_pc_w = 8'h0;
    bus_w.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_w = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (bus_w.rom_addr !== 8'h00) begin errs++; $display("FAIL wrap_addr got %h expected 00", bus_w.rom_addr); end
      end
      if (i >= 3) begin
        exp_o = 8'hF8 + 8'(4 * (i - 3));
        checks += 4;
        if (bus_w.out_valid !== 1'b1) begin errs++; $display("FAIL wrap_valid cyc %0d got %b expected 1", i, bus_w.out_valid); end
        if (bus_w.out_pc !== exp_o) begin errs++; $display("FAIL wrap_pc cyc %0d got %h expected %h", i, bus_w.out_pc, exp_o); end
        if (bus_w.out_insn !== {24'h0, exp_o}) begin errs++; $display("FAIL wrap_insn cyc %0d got %h expected %h", i, bus_w.out_insn, {24'h0, exp_o}); end
        if (count_w !== 3'd1) begin errs++; $display("FAIL wrap_count cyc %0d got %0d expected 1", i, count_w); end
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b0;
    fetch_en = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    bus_m.out_ready = 1'b0;
    rst_w = 1'b0;
    fetch_en_w = 1'b0;
    redirect_w = 1'b0;
    redirect_pc_w = 8'h0;
    bus_w.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end for the 5-stage MIPS core.
- Replaces the bare pc/ce/instruction wiring into the IF/ID register.
- Owns the PC and issues reads to a 1-cycle-latency synchronous instruction ROM.
- Buffers returned words in a DEPTH-entry queue and hands {pc, insn} to decode over valid/ready; branch redirect flushes all queued and in-flight fetches.

Parameters:
- ADDR_W, 32: PC and ROM address width. Wraps modulo 2^ADDR_W.
- DEPTH, 4: queue entries. Power of two, at least 2.
- RESET_PC, 0: PC value after reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; everything is posedge.
- rst  in  1  reset, asynchronous assert, active-low.
- fetch_en  in  1  allow new ROM requests.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored, treated as 00.
- rom_addr  out  ADDR_W  ROM read address.
- rom_ce  out  1  ROM read enable; a request is issued in the cycle it is high.
- rom_data  in  32  ROM word; valid the cycle after the matching rom_ce.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head; a pop happens when out_valid and out_ready are both high.
- out_pc  out  ADDR_W  PC of the head entry.
- out_insn  out  32  instruction of the head entry.
- count  out  clog2(DEPTH)+1  number of occupied entries, for debug and perf.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, queue empty, inflight=0, epoch=0, FSM=IDLE. Outputs: rom_ce=0, rom_addr=RESET_PC, out_valid=0, out_pc=0, out_insn=0, count=0.
- FSM states:
  - IDLE: no issue. Go to RUN on the first cycle with rst=1.
  - RUN: normal fetch.
  - FLUSH: one cycle, entered when redirect=1. No issue. Returns to RUN.
- Issue condition (combinational): FSM==RUN, fetch_en=1, redirect=0, and (count + inflight − pop) < DEPTH.
- On issue: rom_ce=1, rom_addr=pc. At the edge, pc←pc+4, inflight←1, req_pc←pc, req_epoch←epoch. Otherwise inflight←0.
- Response: in the cycle after an issue, rom_data is pushed as {req_pc, rom_data} only if req_epoch==epoch and redirect=0 in that cycle. Otherwise it is discarded.
- Push and pop in the same cycle are both honoured; count is unchanged. Pop of an empty queue is impossible because out_valid=0.
- No bypass: an entry is visible on out_* in the cycle after it is pushed. First instruction appears 2 cycles after its issue.
- Throughput: with out_ready held at 1, one instruction per cycle is sustained for DEPTH≥2.
- Redirect in cycle t takes priority over push, pop and issue in cycle t. At the edge:
  - queue cleared, count←0
  - epoch toggles
  - pc←{redirect_pc[ADDR_W-1:2],2'b00}
  - FSM←FLUSH
- After redirect: the cycle t+1 response is dropped by the epoch mismatch. First issue of the target happens at t+2 (FLUSH occupies t+1).
- Redirect asserted again while in FLUSH: pc is reloaded and epoch toggles again; FSM stays in FLUSH one more cycle.
- Redirect while out_valid and out_ready are both high: the pop is still lost with the flush. Decode must treat an instruction accepted in a redirect cycle as squashed.
- fetch_en=0: no new issues. Any in-flight response still lands; queue drains normally.
- Full queue: no issue. PC holds.
- PC wrap: pc = 2^ADDR_W−4 is followed by 0. No error flag.
- Reset asserted mid-operation: everything returns to reset values immediately. Nothing is pushed afterwards.
- out_pc and out_insn are held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package (mips_defs) holds: INSN_W=32, PC_STEP=4, NOP_INSN=32'h0000_0000, and the fetch FSM state encoding (IDLE/RUN/FLUSH).
- Sub-module ifetch_fifo: synchronous circular FIFO.
  - Params: WIDTH, DEPTH. Ports: push, pop, clear, din, dout, count.
  - Pointers are clog2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
  - clear has priority over push and pop.
- Top level holds the PC, epoch, inflight tracking and the FSM.

Test Plan:
- Streaming fetch: reset release, RESET_PC=0, fetch_en=1, out_ready=1, ROM word = addr.
  - rom_addr = 0,4,8,… on consecutive cycles.
  - out_valid first rises 3 cycles after reset release with out_pc=0, out_insn=0.
  - Thereafter one entry per cycle with pc stepping by 4.
- Backpressure, DEPTH=4, out_ready=0: count reaches 4 and rom_ce drops. out_pc stays 0 until ready. Raising ready gives pops of 0,4,8,C, then refills without any gap or duplicate.
- Redirect: redirect=1, redirect_pc=0x103 while count=3 and a request is in flight.
  - Next cycle count=0 and rom_ce=0.
  - At t+2 rom_addr=0x100; first out_pc=0x100.
  - The stale response is never output.
- Back-to-back redirects to 0x40 then 0x80: no 0x40 entry is ever output; the first output is 0x80.
- Wrap: ADDR_W=8, RESET_PC=0xF8. Output sequence is F8, FC, 00, 04.
- Async reset with count=2: after rst=0, out_valid=0 and rom_ce=0 without waiting for a clock edge. After release, fetch restarts at RESET_PC.
